// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding imem request FSM feeding the IF/ID register.
// Latency: 2 cycles from pc latch to if_valid at the earliest. Backpressure: id_ready low holds IF/ID with pc_hold=1.
// Optional macro FETCH_PARITY_EN adds imem_rparity and an even-parity check on returned words.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_hold,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
`ifdef FETCH_PARITY_EN
    input  logic        imem_rparity,
`endif
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {IDLE, WAIT, FULL, DRAIN} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state, state_nxt;
    logic [31:0] req_pc, req_pc_nxt;
    logic [31:0] addr_nxt, instr_nxt, if_pc_nxt;
    logic        req_nxt, valid_nxt, fault_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        parity_err;

`ifdef FETCH_PARITY_EN
    assign parity_err = ^{imem_rdata, imem_rparity};
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= 32'h0;
            req_pc      <= 32'h0;
            if_valid    <= 1'b0;
            if_instr    <= NOP;
            if_pc       <= 32'h0;
            fetch_fault <= 1'b0;
            cnt         <= 4'h0;
        end else begin
            state       <= state_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            req_pc      <= req_pc_nxt;
            if_valid    <= valid_nxt;
            if_instr    <= instr_nxt;
            if_pc       <= if_pc_nxt;
            fetch_fault <= fault_nxt;
            cnt         <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_nxt    = 1'b0;
        addr_nxt   = imem_addr;
        req_pc_nxt = req_pc;
        valid_nxt  = if_valid;
        instr_nxt  = if_instr;
        if_pc_nxt  = if_pc;
        fault_nxt  = 1'b0;
        cnt_nxt    = cnt;
        pc_hold    = 1'b1;

        if (flush) begin
            // A response still in flight must be swallowed before a new request can go out.
            valid_nxt = 1'b0;
            cnt_nxt   = 4'h0;
            if ((state == WAIT || state == DRAIN) && !imem_rvalid)
                state_nxt = DRAIN;
            else
                state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    pc_hold    = 1'b0;
                    req_pc_nxt = pc;
                    addr_nxt   = pc;
                    req_nxt    = 1'b1;
                    cnt_nxt    = 4'h0;
                    state_nxt  = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid && !parity_err) begin
                        instr_nxt = imem_rdata;
                        if_pc_nxt = req_pc;
                        valid_nxt = 1'b1;
                        state_nxt = FULL;
                    end else if (imem_rvalid || cnt == 4'hF) begin
                        // Bad word or lost response: reissue to the same address.
                        fault_nxt = 1'b1;
                        req_nxt   = 1'b1;
                        cnt_nxt   = 4'h0;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                FULL: begin
                    if (id_ready) begin
                        pc_hold    = 1'b0;
                        req_pc_nxt = pc;
                        addr_nxt   = pc;
                        req_nxt    = 1'b1;
                        valid_nxt  = 1'b0;
                        cnt_nxt    = 4'h0;
                        state_nxt  = WAIT;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (!reset)
            pc_hold = 1'b1;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-003 SHALL have port pc, input, 32: current PC from pc_control.
REQ-004 SHALL have port pc_hold, output, 1: high freezes pc_control; low for exactly the cycle in which pc is latched.
REQ-005 SHALL have port flush, input, 1: redirect in progress; discard all fetch state.
REQ-006 SHALL have ports imem_req (output, 1: one-cycle request pulse) and imem_addr (output, 32: request address, held until next request).
REQ-007 SHALL have ports imem_rdata (input, 32: instruction word) and imem_rvalid (input, 1: rdata valid this cycle); at most one request outstanding.
REQ-008 SHALL have ports if_valid (output, 1), if_instr (output, 32) and if_pc (output, 32): IF/ID register contents.
REQ-009 SHALL have port id_ready, input, 1: decode accepts if_instr when if_valid and id_ready are both high at an edge.
REQ-010 SHALL have port fetch_fault, output, 1: one-cycle pulse on timeout or parity error.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, FULL and DRAIN.
REQ-012 IDLE (no flush) SHALL, at the next edge: latch pc into req_pc and imem_addr, pulse imem_req, go WAIT; pc_hold=0 in that cycle.
REQ-013 WAIT on imem_rvalid (no flush, no parity error) SHALL, at the edge: if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1, go FULL; minimum pc-latch-to-if_valid latency is 2 cycles.
REQ-014 FULL with id_ready=1 (no flush) SHALL latch the next pc, pulse imem_req, clear if_valid, go WAIT, with pc_hold=0 that cycle; with id_ready=0, all outputs are held and pc_hold=1.
REQ-015 pc_hold SHALL be 1 in every cycle except those named in REQ-012 and REQ-014.
REQ-016 WAIT SHALL run a 4-bit timeout counter, cleared on each request; if 16 cycles pass without imem_rvalid, it SHALL pulse fetch_fault, re-pulse imem_req with the same imem_addr, and clear the counter.
REQ-017 A response arriving after a timeout reissue SHALL be accepted as the reissued response (same address).
REQ-018 flush SHALL take priority over every other event: if_valid<=0, counter cleared, no imem_req, pc_hold=1.
REQ-019 Under flush, the next state SHALL be: WAIT without imem_rvalid -> DRAIN; WAIT with imem_rvalid -> IDLE (data dropped); DRAIN without imem_rvalid -> DRAIN; all other cases -> IDLE.
REQ-020 DRAIN SHALL discard the first imem_rvalid and go IDLE; it SHALL never issue requests.
REQ-021 imem_rvalid in IDLE or FULL SHALL be ignored.

Reset
REQ-022 reset=0 at an edge SHALL force: state IDLE, imem_req=0, imem_addr=0, req_pc=0, if_valid=0, if_instr=32'h00000013, if_pc=0, fetch_fault=0, counter=0.
REQ-023 pc_hold SHALL be 1 while reset=0; an outstanding response is treated as lost (the memory is reset with the core).
REQ-024 The first request SHALL issue at the first edge after reset returns to 1.

Configuration
REQ-025 With macro FETCH_PARITY_EN defined: input imem_rparity (1 bit) SHALL exist; in WAIT, on imem_rvalid, if ^{imem_rdata,imem_rparity}=1 (even parity fails), the word is discarded, fetch_fault pulses and imem_req re-pulses to the same address, staying in WAIT.
REQ-026 Without FETCH_PARITY_EN: the imem_rparity port SHALL be absent and no parity check is made.

Verification
REQ-027 Reset held 3 cycles, then released with pc=0 -> imem_req pulse with imem_addr=0 on the 1st edge after release; pc_hold=0 for that cycle only.
REQ-028 rvalid 2 cycles after request, rdata=0x00500093, id_ready=1 -> if_valid=1, if_instr=0x00500093, if_pc=0; next request to pc=0x4 in the same cycle as the handshake.
REQ-029 FULL with id_ready=0 for 3 cycles -> if_instr/if_pc stable, pc_hold=1, no imem_req; id_ready=1 -> request issued.
REQ-030 flush in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> if_valid stays 0, state DRAIN->IDLE, next request uses the new pc=0x20.
REQ-031 No rvalid for 16 cycles -> fetch_fault pulse, imem_req re-pulsed to the same address; rvalid later -> normal capture.
REQ-032 FETCH_PARITY_EN defined, rdata=0x00000013 with imem_rparity=0 (^=1) -> fetch_fault pulse, retry; imem_rparity=1 on retry -> if_valid=1.
